// File: rtl/dosis_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : dosis_scheduler_if
// Description : Dispense request/acknowledge handshake between the dose
//               scheduler (master) and the pill-dispenser actuator (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface dosis_scheduler_if #(
    parameter int NUM_SLOTS = 4
) ();
    logic                         disp_req;
    logic [$clog2(NUM_SLOTS)-1:0] disp_slot;
    logic                         disp_ack;

    modport master (
        output disp_req,
        output disp_slot,
        input  disp_ack
    );

    modport slave (
        input  disp_req,
        input  disp_slot,
        output disp_ack
    );
endinterface
`default_nettype wire

// File: rtl/dosis_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dosis_scheduler
// Description : Daily dose-time scheduler. Compares the BCD HH:MM time word
//               against NUM_SLOTS programmable slots, queues due doses and
//               serves them one at a time over a req/ack handshake, raising
//               an alarm and counting misses when a request times out.
//               Optional macro REINTENTO_EN: one retry before a dose is
//               declared missed.
// Revision    : 1.0 - initial release
// ============================================================================
module dosis_scheduler #(
    parameter int NUM_SLOTS    = 4,
    parameter int ACK_TIMEOUT  = 50000,
    parameter int ALARM_CYCLES = 20000
) (
    input  wire logic                         clk,
    input  wire logic                         rst_n,
    input  wire logic [23:0]                  tiempo,
    input  wire logic                         cfg_we,
    input  wire logic [$clog2(NUM_SLOTS)-1:0] cfg_slot,
    input  wire logic [7:0]                   cfg_hora,
    input  wire logic [7:0]                   cfg_min,
    input  wire logic                         cfg_en,
    output logic      [NUM_SLOTS-1:0]         pending,
    output logic                              alarma,
    output logic      [7:0]                   missed_cnt,
    dosis_scheduler_if.master                 disp
);

    localparam int c_slot_w  = $clog2(NUM_SLOTS);
    localparam int c_cnt_max = (ACK_TIMEOUT > ALARM_CYCLES) ? ACK_TIMEOUT : ALARM_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_ack_last   = c_cnt_w'(ACK_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_alarm_last = c_cnt_w'(ALARM_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_MISS = 2'd2
    } state_t;

    logic [7:0]           r_hora [NUM_SLOTS];
    logic [7:0]           r_min  [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] r_en;
    logic [15:0]          r_tiempo_q;
    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;

    logic                 w_new_min;
    logic                 w_cfg_ok;
    logic [NUM_SLOTS-1:0] w_set;
    logic [NUM_SLOTS-1:0] w_clr;
    logic [c_slot_w-1:0]  w_low_idx;
    logic                 w_ack;
    logic                 w_timeout;
    logic                 w_final;

    // Day digits are carried on the bus but play no part in scheduling.
    logic w_unused_day;
    assign w_unused_day = &{1'b0, tiempo[23:16]};

`ifdef REINTENTO_EN
    logic                r_retry;
    logic [c_slot_w-1:0] r_retry_slot;
`endif

    // Previous HH:MM, loaded unconditionally so reset cannot cause a false edge.
    always_ff @(posedge clk) begin
        r_tiempo_q <= tiempo[15:0];
    end

    assign w_new_min = (tiempo[15:0] != r_tiempo_q);

    // A write must be valid BCD, within 00:00..23:59, and address a real slot.
    assign w_cfg_ok = (cfg_hora[7:4] <= 4'd9) && (cfg_hora[3:0] <= 4'd9) &&
                      (cfg_min[7:4]  <= 4'd9) && (cfg_min[3:0]  <= 4'd9) &&
                      (cfg_hora <= 8'h23) && (cfg_min <= 8'h59) &&
                      (int'(cfg_slot) < NUM_SLOTS);

    // Slot configuration registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_hora[i] <= 8'h00;
                r_min[i]  <= 8'h00;
            end
            r_en <= '0;
        end else if (cfg_we && w_cfg_ok) begin
            r_hora[cfg_slot] <= cfg_hora;
            r_min[cfg_slot]  <= cfg_min;
            r_en[cfg_slot]   <= cfg_en;
        end
    end

    generate
        for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_match
            assign w_set[i] = w_new_min && r_en[i] &&
                              ({r_hora[i], r_min[i]} == tiempo[15:0]);
        end
    endgenerate

    assign w_ack     = (r_state == S_REQ) && disp.disp_ack;
    assign w_timeout = (r_state == S_REQ) && !disp.disp_ack && (r_cnt == c_ack_last);
`ifdef REINTENTO_EN
    assign w_final   = w_timeout && r_retry && (r_retry_slot == disp.disp_slot);
`else
    assign w_final   = w_timeout;
`endif

    // Pending bit of the slot in service is dropped on ack or on a final miss.
    always_comb begin
        w_clr = '0;
        if (w_ack || w_final) begin
            w_clr[disp.disp_slot] = 1'b1;
        end
    end

    // Lowest-index pending slot is served first.
    always_comb begin
        w_low_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                w_low_idx = c_slot_w'(i);
            end
        end
    end

    // Dose-due queue; a new trigger beats a same-cycle clear so no dose is lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~w_clr) | w_set;
        end
    end

    // Request / timeout / alarm sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            disp.disp_req  <= 1'b0;
            disp.disp_slot <= '0;
            alarma         <= 1'b0;
            missed_cnt     <= 8'd0;
`ifdef REINTENTO_EN
            r_retry        <= 1'b0;
            r_retry_slot   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|pending) begin
                        disp.disp_slot <= w_low_idx;
                        disp.disp_req  <= 1'b1;
                        r_cnt          <= '0;
                        r_state        <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (disp.disp_ack) begin
                        disp.disp_req <= 1'b0;
                        r_state       <= S_IDLE;
`ifdef REINTENTO_EN
                        r_retry       <= 1'b0;
`endif
                    end else if (w_timeout) begin
                        disp.disp_req <= 1'b0;
                        alarma        <= 1'b1;
                        r_cnt         <= '0;
                        r_state       <= S_MISS;
`ifdef REINTENTO_EN
                        if (w_final) begin
                            if (missed_cnt != 8'hFF) begin
                                missed_cnt <= missed_cnt + 8'd1;
                            end
                            r_retry <= 1'b0;
                        end else begin
                            r_retry      <= 1'b1;
                            r_retry_slot <= disp.disp_slot;
                        end
`else
                        if (missed_cnt != 8'hFF) begin
                            missed_cnt <= missed_cnt + 8'd1;
                        end
`endif
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                S_MISS: begin
                    if (r_cnt == c_alarm_last) begin
                        alarma  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
